// File: rtl/keypad_lock_if.sv
// keypad_lock_if: keypad input and lock status bundle.
// master drives the raw keypad code; slave is the lock controller.
interface keypad_lock_if #(
    parameter int DIGITS = 3
);
    logic [15:0]         onehot;
    logic [4*DIGITS-1:0] digits;
    logic [3:0]          count;
    logic [3:0]          tries;
    logic [1:0]          state;
    logic                unlocked;
    logic                buzzer;

    modport master (
        output onehot,
        input  digits, count, tries, state, unlocked, buzzer
    );

    modport slave (
        input  onehot,
        output digits, count, tries, state, unlocked, buzzer
    );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: BCD keypad code lock with timed lockout after wrong codes.
// Define KEYPAD_LOCK_BUZZER_EN to build the click/success/fail tone generator.
module keypad_lock_ctrl #(
    parameter int                  DIGITS    = 3,
    parameter logic [4*DIGITS-1:0] PASSWORD  = (4*DIGITS)'(12'h246),
    parameter int                  MAX_TRIES = 3,
    parameter int                  CLK_HZ    = 50_000_000,
    parameter int                  LOCK_SECS = 60
) (
    input logic          clk,
    input logic          rst_n,
    keypad_lock_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(CLK_HZ) + 1;

    localparam logic [7:0]    LOCK_BCD = {4'(LOCK_SECS / 10), 4'(LOCK_SECS % 10)};
    localparam logic [3:0]    DIG_N    = 4'(DIGITS);
    localparam logic [3:0]    TRY_N    = 4'(MAX_TRIES);
    localparam logic [PW-1:0] PRE_TOP  = PW'(CLK_HZ - 1);
    localparam logic [W-1:0]  BLANK    = {DIGITS{4'hF}};
    localparam logic [W-1:0]  OPENED   = {DIGITS{4'hA}};

    localparam logic [3:0] K_ENTER = 4'd10;
    localparam logic [3:0] K_CLEAR = 4'd11;
    localparam logic [3:0] K_ADMIN = 4'd12;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } st_e;

    typedef enum logic [1:0] {
        T_CLICK = 2'd0,
        T_OK    = 2'd1,
        T_FAIL  = 2'd2
    } tone_e;

    logic          dec_v;
    logic [3:0]    dec_c;
    logic          key_v, prev_v, evt;
    logic [3:0]    key_c, evt_c;
    st_e           st;
    logic [W-1:0]  digits_q;
    logic [3:0]    count_q, tries_q;
    logic          unlocked_q;
    logic [7:0]    sec_q;
    logic [PW-1:0] pre_q;
    logic          tone_go;
    tone_e         tone_k;

    logic is_dig, is_ent, is_clr, is_adm, full, match, tick;

    function automatic logic [W-1:0] lock_disp(input logic [7:0] s);
        logic [W+7:0] t;
        t = {BLANK, s};
        return t[W-1:0];
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] s);
        if (s[3:0] == 4'd0)
            return {s[7:4] - 4'd1, 4'd9};
        return {s[7:4], s[3:0] - 4'd1};
    endfunction

    // Map the raw keypad code to a key number; unknown codes mean no key
    always_comb begin
        dec_v = 1'b1;
        dec_c = 4'd0;
        case (bus.onehot)
            16'h0008: dec_c = 4'd0;
            16'h0080: dec_c = 4'd1;
            16'h0040: dec_c = 4'd2;
            16'h0020: dec_c = 4'd3;
            16'h0800: dec_c = 4'd4;
            16'h0400: dec_c = 4'd5;
            16'h0200: dec_c = 4'd6;
            16'h8000: dec_c = 4'd7;
            16'h4000: dec_c = 4'd8;
            16'h2000: dec_c = 4'd9;
            16'h0001: dec_c = K_ENTER;
            16'h1000: dec_c = K_CLEAR;
            16'h0100: dec_c = K_ADMIN;
            default:  dec_v = 1'b0;
        endcase
    end

    // Register the decoded key and flag a single event per none-to-key edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_v  <= 1'b0;
            key_c  <= 4'd0;
            prev_v <= 1'b0;
            evt    <= 1'b0;
            evt_c  <= 4'd0;
        end else begin
            key_v  <= dec_v;
            key_c  <= dec_c;
            prev_v <= key_v;
            evt    <= key_v & ~prev_v;
            evt_c  <= key_c;
        end
    end

    assign is_dig = evt && (evt_c <= 4'd9);
    assign is_ent = evt && (evt_c == K_ENTER);
    assign is_clr = evt && (evt_c == K_CLEAR);
    assign is_adm = evt && (evt_c == K_ADMIN);
    assign full   = (count_q == DIG_N);
    assign match  = (digits_q == PASSWORD);
    assign tick   = (pre_q == PRE_TOP);

    // Lock state machine: code entry, open, and timed lockout countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ENTRY;
            digits_q   <= BLANK;
            count_q    <= 4'd0;
            tries_q    <= 4'd0;
            unlocked_q <= 1'b0;
            sec_q      <= 8'd0;
            pre_q      <= '0;
            tone_go    <= 1'b0;
            tone_k     <= T_CLICK;
        end else begin
            tone_go <= 1'b0;
            if (is_adm) begin
                st         <= ENTRY;
                digits_q   <= BLANK;
                count_q    <= 4'd0;
                tries_q    <= 4'd0;
                unlocked_q <= 1'b0;
                sec_q      <= 8'd0;
                pre_q      <= '0;
                tone_go    <= 1'b1;
                tone_k     <= T_CLICK;
            end else begin
                unique case (st)
                    ENTRY: begin
                        if (is_dig) begin
                            tone_go <= 1'b1;
                            tone_k  <= T_CLICK;
                            if (!full) begin
                                digits_q <= (digits_q << 4) | W'(evt_c);
                                count_q  <= count_q + 4'd1;
                            end
                        end else if (is_ent && full) begin
                            tone_go <= 1'b1;
                            count_q <= 4'd0;
                            if (match) begin
                                st         <= OPEN;
                                digits_q   <= OPENED;
                                tries_q    <= 4'd0;
                                unlocked_q <= 1'b1;
                                tone_k     <= T_OK;
                            end else begin
                                digits_q <= BLANK;
                                tone_k   <= T_FAIL;
                                if (tries_q + 4'd1 == TRY_N) begin
                                    st       <= LOCKOUT;
                                    tries_q  <= 4'd0;
                                    sec_q    <= LOCK_BCD;
                                    pre_q    <= '0;
                                    digits_q <= lock_disp(LOCK_BCD);
                                end else begin
                                    tries_q <= tries_q + 4'd1;
                                end
                            end
                        end else if (is_clr) begin
                            digits_q <= BLANK;
                            count_q  <= 4'd0;
                            tone_go  <= 1'b1;
                            tone_k   <= T_CLICK;
                        end
                    end
                    OPEN: begin
                        if (is_dig) begin
                            tone_go <= 1'b1;
                            tone_k  <= T_CLICK;
                        end else if (is_clr) begin
                            st         <= ENTRY;
                            digits_q   <= BLANK;
                            count_q    <= 4'd0;
                            unlocked_q <= 1'b0;
                            tone_go    <= 1'b1;
                            tone_k     <= T_CLICK;
                        end
                    end
                    LOCKOUT: begin
                        if (tick) begin
                            pre_q <= '0;
                            if (sec_q == 8'd0) begin
                                st       <= ENTRY;
                                digits_q <= BLANK;
                            end else begin
                                sec_q    <= bcd_dec(sec_q);
                                digits_q <= lock_disp(bcd_dec(sec_q));
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                    default: st <= ENTRY;
                endcase
            end
        end
    end

    assign bus.digits   = digits_q;
    assign bus.count    = count_q;
    assign bus.tries    = tries_q;
    assign bus.state    = st;
    assign bus.unlocked = unlocked_q;

`ifdef KEYPAD_LOCK_BUZZER_EN
    // Half-period floors at one cycle so very low clock rates still toggle
    localparam logic [31:0] CLICK_H = (CLK_HZ / 1000 > 0) ? 32'(CLK_HZ / 1000) : 32'd1;
    localparam logic [31:0] OK_H    = (CLK_HZ / 2000 > 0) ? 32'(CLK_HZ / 2000) : 32'd1;
    localparam logic [31:0] FAIL_H  = (CLK_HZ / 500 > 0) ? 32'(CLK_HZ / 500) : 32'd1;
    localparam logic [31:0] CLICK_D = 32'(CLK_HZ / 5);
    localparam logic [31:0] OK_D    = 32'((3 * CLK_HZ) / 5);
    localparam logic [31:0] FAIL_D  = 32'((3 * CLK_HZ) / 10);
    localparam logic [31:0] FAIL_G0 = 32'(CLK_HZ / 10);
    localparam logic [31:0] FAIL_G1 = 32'(CLK_HZ / 5);

    logic        tone_on, buzz_q, in_gap;
    tone_e       tone_q;
    logic [31:0] dur_q, half_q, dur_nx, half_lim, dur_lim;

    // Pick pitch, length and silent window for the tone now playing
    always_comb begin
        dur_nx   = dur_q + 32'd1;
        half_lim = CLICK_H;
        dur_lim  = CLICK_D;
        in_gap   = 1'b0;
        unique case (tone_q)
            T_OK: begin
                half_lim = OK_H;
                dur_lim  = OK_D;
            end
            T_FAIL: begin
                half_lim = FAIL_H;
                dur_lim  = FAIL_D;
                in_gap   = (dur_nx >= FAIL_G0) && (dur_nx < FAIL_G1);
            end
            default: ;
        endcase
    end

    // Square-wave generator; a new request always restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_on <= 1'b0;
            tone_q  <= T_CLICK;
            dur_q   <= 32'd0;
            half_q  <= 32'd0;
            buzz_q  <= 1'b0;
        end else if (tone_go) begin
            tone_on <= 1'b1;
            tone_q  <= tone_k;
            dur_q   <= 32'd0;
            half_q  <= 32'd0;
            buzz_q  <= 1'b1;
        end else if (tone_on) begin
            dur_q <= dur_nx;
            if (dur_nx >= dur_lim) begin
                tone_on <= 1'b0;
                buzz_q  <= 1'b0;
            end else if (in_gap) begin
                half_q <= 32'd0;
                buzz_q <= 1'b0;
            end else if (half_q + 32'd1 >= half_lim) begin
                half_q <= 32'd0;
                buzz_q <= ~buzz_q;
            end else begin
                half_q <= half_q + 32'd1;
            end
        end
    end

    assign bus.buzzer = buzz_q;
`else
    logic unused_tone;
    assign unused_tone = ^{tone_go, tone_k};
    assign bus.buzzer  = 1'b0;
`endif
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl: directed and random key sequences against a
// transaction-level model of the lock (entered digits, tries, lockout time).
module tb_keypad_lock_ctrl;
    localparam int DIGITS    = 3;
    localparam int MAX_TRIES = 3;
    localparam int CLK_HZ    = 1000;
    localparam int LOCK_SECS = 3;
    localparam int PASS_VAL  = 246;
    localparam int LOCK_LEN  = (LOCK_SECS + 1) * CLK_HZ;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    keypad_lock_if #(.DIGITS(DIGITS)) bus ();

    keypad_lock_ctrl #(
        .DIGITS   (DIGITS),
        .PASSWORD (12'h246),
        .MAX_TRIES(MAX_TRIES),
        .CLK_HZ   (CLK_HZ),
        .LOCK_SECS(LOCK_SECS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // model: 0 entry, 1 open, 2 lockout
    int m_state;
    int m_tries;
    int m_buf[$];
    int m_t0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] key_hot(input int k);
        case (k)
            0:  return 16'h0008;
            1:  return 16'h0080;
            2:  return 16'h0040;
            3:  return 16'h0020;
            4:  return 16'h0800;
            5:  return 16'h0400;
            6:  return 16'h0200;
            7:  return 16'h8000;
            8:  return 16'h4000;
            9:  return 16'h2000;
            10: return 16'h0001;
            11: return 16'h1000;
            12: return 16'h0100;
            default: return 16'h0003;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_tries = 0;
        m_buf.delete();
        m_t0 = 0;
    endtask

    task automatic model_expire(input int c);
        if (m_state == 2 && c - m_t0 >= LOCK_LEN) begin
            m_state = 0;
            m_buf.delete();
        end
    endtask

    task automatic model_key(input int k, input int e);
        bit drop;
        int v;
        drop = (m_state == 2) && (e - m_t0 == LOCK_LEN);
        model_expire(e);
        if (k < 0 || k > 12) return;
        if (k == 12) begin
            m_state = 0;
            m_tries = 0;
            m_buf.delete();
            return;
        end
        if (drop) return;
        case (m_state)
            0: begin
                if (k <= 9) begin
                    if (m_buf.size() < DIGITS) m_buf.push_back(k);
                end else if (k == 10) begin
                    if (m_buf.size() == DIGITS) begin
                        v = 0;
                        foreach (m_buf[i]) v = v * 10 + m_buf[i];
                        m_buf.delete();
                        if (v == PASS_VAL) begin
                            m_state = 1;
                            m_tries = 0;
                        end else begin
                            m_tries++;
                            if (m_tries == MAX_TRIES) begin
                                m_state = 2;
                                m_tries = 0;
                                m_t0 = e;
                            end
                        end
                    end
                end else if (k == 11) begin
                    m_buf.delete();
                end
            end
            1: begin
                if (k == 11) begin
                    m_state = 0;
                    m_buf.delete();
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [11:0] exp_digits(input int c);
        logic [11:0] d;
        int s;
        int n;
        d = 12'hFFF;
        n = m_buf.size();
        case (m_state)
            0: for (int i = 0; i < n; i++)
                   d[4*(n-1-i) +: 4] = 4'(m_buf[i]);
            1: d = 12'hAAA;
            default: begin
                s = LOCK_SECS - (c - m_t0) / CLK_HZ;
                d = {4'hF, 4'(s / 10), 4'(s % 10)};
            end
        endcase
        return d;
    endfunction

    task automatic check_all();
        model_expire(cyc);
        check("state", 32'(bus.state), 32'(m_state));
        check("digits", 32'(bus.digits), 32'(exp_digits(cyc)));
        check("count", 32'(bus.count), (m_state == 0) ? m_buf.size() : 0);
        check("tries", 32'(bus.tries), 32'(m_tries));
        check("unlocked", 32'(bus.unlocked), (m_state == 1) ? 1 : 0);
`ifndef KEYPAD_LOCK_BUZZER_EN
        check("buzzer_off", 32'(bus.buzzer), 0);
`endif
    endtask

    // state/display settle three edges after the key appears
    task automatic press(input int k, input int hold);
        int pc;
        @(negedge clk);
        bus.onehot = key_hot(k);
        pc = cyc;
        repeat (hold) @(negedge clk);
        bus.onehot = 16'h0000;
        repeat (3) @(negedge clk);
        model_key(k, pc + 3);
        check_all();
    endtask

    task automatic count_toggles(input int n, output int t);
        logic p;
        t = 0;
        p = bus.buzzer;
        repeat (n) begin
            @(negedge clk);
            if (bus.buzzer !== p) t++;
            p = bus.buzzer;
        end
    endtask

    int tg;
    int pc;

    initial begin
        bus.onehot = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(bus.digits), 32'h0FFF);
        check("rst_state", 32'(bus.state), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_tries", 32'(bus.tries), 0);
        check("rst_unlocked", 32'(bus.unlocked), 0);
        check("rst_buzzer", 32'(bus.buzzer), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // correct code opens the lock with the success tone
        press(2, 3);
        press(4, 3);
        press(6, 3);
        press(10, 2);
        check("open_state", 32'(bus.state), 1);
        check("open_digits", 32'(bus.digits), 32'h0AAA);
        count_toggles(300, tg);
`ifdef KEYPAD_LOCK_BUZZER_EN
        check("ok_tone_toggles", tg, 300);
`else
        check("ok_tone_toggles", tg, 0);
`endif
        repeat (400) @(negedge clk);
        check("tone_idle", 32'(bus.buzzer), 0);
        press(11, 3);

        // three wrong codes lead to lockout
        for (int n = 0; n < 3; n++) begin
            press(1, 3);
            press(2, 3);
            press(3, 3);
            press(10, 2);
            if (n == 0) begin
                count_toggles(80, tg);
`ifdef KEYPAD_LOCK_BUZZER_EN
                check("fail_tone_toggles", tg, 40);
`else
                check("fail_tone_toggles", tg, 0);
`endif
                repeat (40) @(negedge clk);
                count_toggles(59, tg);
                check("fail_gap_toggles", tg, 0);
                check("fail_gap_level", 32'(bus.buzzer), 0);
            end
            if (n < 2) check("tries_step", 32'(bus.tries), n + 1);
        end
        check("lock_state", 32'(bus.state), 2);
        check("lock_digits", 32'(bus.digits), 32'h0F03);
        for (int s = 0; s < 4; s++) begin
            while (cyc < m_t0 + 500 + 1000 * s) @(negedge clk);
            check("lock_count", 32'(bus.digits), 32'(12'hF03 - 12'(s)));
            check_all();
        end
        while (cyc < m_t0 + 4500) @(negedge clk);
        check("lock_end_state", 32'(bus.state), 0);
        check("lock_end_digits", 32'(bus.digits), 32'h0FFF);
        check_all();

        // second lockout: digits ignored, ADMIN exits one cycle after detect
        for (int n = 0; n < 3; n++) begin
            press(9, 2);
            press(9, 2);
            press(9, 2);
            press(10, 2);
        end
        press(2, 3);
        check("lock_ignore", 32'(bus.digits), 32'h0F03);
        @(negedge clk);
        bus.onehot = key_hot(12);
        pc = cyc;
        repeat (2) @(negedge clk);
        check("admin_before", 32'(bus.state), 2);
        @(negedge clk);
        check("admin_state", 32'(bus.state), 0);
        check("admin_digits", 32'(bus.digits), 32'h0FFF);
        check("admin_tries", 32'(bus.tries), 0);
        bus.onehot = 16'h0000;
        repeat (3) @(negedge clk);
        model_key(12, pc + 3);
        check_all();

        // partial entry, overflow digit, long hold
        press(1, 3);
        press(2, 3);
        press(10, 3);
        check("short_enter", 32'(bus.digits), 32'h0F12);
        press(3, 3);
        press(4, 3);
        check("full_count", 32'(bus.count), 3);
        check("full_digits", 32'(bus.digits), 32'h0123);
        press(11, 3);
        press(7, 50);
        check("held_key", 32'(bus.digits), 32'h0FF7);
        press(8, 1);
        press(12, 3);

        // reset in the middle of a success tone
        press(2, 3);
        press(4, 3);
        press(6, 3);
        press(10, 2);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tone_buzzer", 32'(bus.buzzer), 0);
        check("rst_tone_digits", 32'(bus.digits), 32'h0FFF);
        check("rst_tone_state", 32'(bus.state), 0);
        check("rst_tone_unlocked", 32'(bus.unlocked), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // reset in the middle of code entry
        press(5, 3);
        press(6, 3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_entry_digits", 32'(bus.digits), 32'h0FFF);
        check("rst_entry_count", 32'(bus.count), 0);
        check("rst_entry_state", 32'(bus.state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        press(4, 3);
        check("post_rst_key", 32'(bus.digits), 32'h0FF4);

        // random key traffic against the model
        for (int it = 0; it < 150; it++) begin
            int r;
            int h;
            r = $urandom_range(0, 99);
            h = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(1, 6);
            if (r < 45) begin
                if ($urandom_range(0, 1) == 1)
                    press(2 + 2 * $urandom_range(0, 2), h);
                else
                    press($urandom_range(0, 9), h);
            end else if (r < 55) begin
                press(2, h);
                press(4, h);
                press(6, h);
            end else if (r < 75) begin
                press(10, h);
            end else if (r < 82) begin
                press(11, h);
            end else if (r < 86) begin
                press(12, h);
            end else if (r < 92) begin
                press(13, h);
            end else begin
                repeat ($urandom_range(300, 1500)) @(negedge clk);
                check_all();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
